ppu_vram_arbiter: RTL and testbench
===================================

// Module: ppu_vram_arbiter
// PURPOSE
//  Time-shares the single-port 2 KiB nametable VRAM between the PPU render fetch path (priority)
//  and CPU PPUDATA accesses from the register interface. Buffers one CPU request and issues it in
//  a free PPU slot. Applies nametable mirroring; a starvation guard bounds CPU wait during rendering.
// PARAMETERS
//  STARVE_LIMIT  16  ppu ticks a pending CPU request may be blocked before it is forced through
//  CNT_W         5   width of starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   reset, asynchronous, active-low
//  ppu_clk_en     in   1   PPU tick; all arbitration/state advances only when high
//  mirroring      in   mirror_t  nametable mirroring mode
//  rend_req       in   1   render fetch request, valid on a ppu tick
//  rend_addr      in   14  render PPU address
//  rend_rd_valid  out  1   read data valid (one ppu tick after grant)
//  rend_rd_data   out  8   render read data
//  rend_stall     out  1   registered; high for the ppu tick after a render request was denied
//  cpu_req        in   1   one-clk pulse: CPU access request
//  cpu_we         in   1   1 write, 0 read; sampled with cpu_req
//  cpu_addr       in   14  CPU PPU address; sampled with cpu_req
//  cpu_wr_data    in   8   write data; sampled with cpu_req
//  cpu_busy       out  1   request buffered/in flight
//  cpu_done       out  1   level; set on completion, cleared when next cpu_req is accepted
//  cpu_rd_data    out  8   registered CPU read result
//  vram_addr      out  11  VRAM address (combinational from this tick's grant)
//  vram_re/we     out  1   VRAM read/write strobes, only on ppu ticks
//  vram_wr_data   out  8   VRAM write data
//  vram_rd_data   in   8   sync-read data, valid on the ppu tick after vram_re
// BEHAVIOUR
//  Reset: CPU FSM C_IDLE; rend_rd_valid, rend_stall, cpu_busy, cpu_done = 0; cpu_rd_data = 8'h00;
//   starve counter = 0. Reset mid-operation discards the buffered request; no done is reported.
//  Decode: address in range when 14'h2000 <= addr <= 14'h3EFF. Maps to VRAM as follows:
//   VER_MIRROR {addr[10],addr[9:0]}; HOR_MIRROR {addr[11],addr[9:0]}; other values {1'b0,addr[9:0]}.
//   Out-of-range access drives no strobe. Its read returns 8'h00, and it still completes/valids.
//  CPU FSM: C_IDLE -cpu_req-> C_PEND (latch we/addr/data, clear cpu_done, busy=1).
//   cpu_req while busy: ignored. cpu_req is captured on any clk and is not gated by ppu_clk_en.
//   Grant needs a ppu tick. A request captured on a ppu-tick edge is first eligible on the next tick.
//   C_PEND: granted on a ppu tick with !rend_req or starve counter == STARVE_LIMIT.
//    Write grant -> C_IDLE, cpu_done=1, busy=0.
//    Read grant  -> C_RDWAIT.
//   C_RDWAIT: next ppu tick: cpu_rd_data <= vram_rd_data (or 00 if OOR), done=1, busy=0 -> C_IDLE.
//  Render: rend_req on a ppu tick is granted unless the CPU is force-granted that tick.
//   Granted: vram_re that tick. rend_rd_valid=1 on the next ppu tick (held for that tick only).
//   rend_rd_data = vram_rd_data, or 00 if OOR.
//   Denied: no valid. rend_stall=1 for the next ppu tick. The render side must re-request.
//  Starvation: counter increments per ppu tick in C_PEND with rend_req high. It is cleared on grant.
//   It saturates at STARVE_LIMIT.
//  Pipelined render reads back-to-back every tick are allowed. C_RDWAIT does not block render grants.
//  Mirroring is sampled at the grant tick. A change mid-request affects only later grants.
//  vram_we and vram_re are never both high. At most one access per ppu tick.
// STRUCTURE
//  Package ppu_defines.vh: mirror_t (existing); add cpu_arb_state_t {C_IDLE,C_PEND,C_RDWAIT} and
//   the VRAM_NT_LO/HI range constants.
//  Sub-module vram_mirror_map (combinational: addr[13:0], mirroring -> vram_addr[10:0], in_range).
//   It is instantiated once on the muxed grant address.
// TESTING
//  1 VER_MIRROR, idle render; CPU write 0x2C05=0xAB.
//    -> vram_we at next tick, vram_addr=0x405, cpu_done=1, busy=0.
//  2 HOR_MIRROR CPU read 0x2C05, no render.
//    -> vram_re with vram_addr=0x405; one tick later cpu_rd_data=RAM value, done=1.
//  3 rend_req every tick for 40 ticks, CPU read pending.
//    -> forced grant on tick 17 (STARVE_LIMIT=16); rend_stall=1 next tick; render resumes after.
//  4 Render read 0x23C0 and CPU read in alternate free slots.
//    -> no tick with two strobes; each rend_rd_valid one tick after its grant.
//  5 CPU write 0x3F00 (palette, OOR) and read 0x1000.
//    -> no strobes; read returns 00; cpu_done set for both.
//  6 cpu_req while busy ignored; rst_n low during C_RDWAIT.
//    -> all outputs reset, done=0; next request serviced normally.

Source files
------------

// File: rtl/ppu_vram_arbiter_pkg.sv
// ============================================================================
// ppu_vram_arbiter_pkg : shared types and constants for the nametable arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package ppu_vram_arbiter_pkg;

  typedef enum logic [1:0] {
    VER_MIRROR = 2'd0,
    HOR_MIRROR = 2'd1,
    ONE_LO     = 2'd2,
    ONE_HI     = 2'd3
  } mirror_t;

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_PEND   = 2'd1,
    C_RDWAIT = 2'd2
  } cpu_arb_state_t;

  localparam logic [13:0] VRAM_NT_LO = 14'h2000;
  localparam logic [13:0] VRAM_NT_HI = 14'h3EFF;

endpackage

`default_nettype wire

// File: rtl/ppu_vram_arbiter_if.sv
// ============================================================================
// ppu_vram_arbiter_if : render, CPU and VRAM-side signals of the arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface ppu_vram_arbiter_if;

  logic        rend_req;
  logic [13:0] rend_addr;
  logic        rend_rd_valid;
  logic [7:0]  rend_rd_data;
  logic        rend_stall;

  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_busy;
  logic        cpu_done;
  logic [7:0]  cpu_rd_data;

  logic [10:0] vram_addr;
  logic        vram_re;
  logic        vram_we;
  logic [7:0]  vram_wr_data;
  logic [7:0]  vram_rd_data;

  modport master (
    output rend_req, rend_addr, cpu_req, cpu_we, cpu_addr, cpu_wr_data, vram_rd_data,
    input  rend_rd_valid, rend_rd_data, rend_stall, cpu_busy, cpu_done, cpu_rd_data,
           vram_addr, vram_re, vram_we, vram_wr_data
  );

  modport slave (
    input  rend_req, rend_addr, cpu_req, cpu_we, cpu_addr, cpu_wr_data, vram_rd_data,
    output rend_rd_valid, rend_rd_data, rend_stall, cpu_busy, cpu_done, cpu_rd_data,
           vram_addr, vram_re, vram_we, vram_wr_data
  );

endinterface

`default_nettype wire

// File: rtl/ppu_vram_arbiter_vram_mirror_map.sv
// ============================================================================
// vram_mirror_map : PPU address -> 2 KiB nametable address with mirroring
// Revision 1.0
// ============================================================================
`default_nettype none

module vram_mirror_map
  import ppu_vram_arbiter_pkg::*;
(
  input  logic [13:0] addr,
  input  mirror_t     mirroring,
  output logic [10:0] vram_addr,
  output logic        in_range
);

  always_comb begin
    vram_addr = {1'b0, addr[9:0]};
    case (mirroring)
      VER_MIRROR: vram_addr = {addr[10], addr[9:0]};
      HOR_MIRROR: vram_addr = {addr[11], addr[9:0]};
      default:    vram_addr = {1'b0, addr[9:0]};
    endcase
    in_range = (addr >= VRAM_NT_LO) && (addr <= VRAM_NT_HI);
  end

endmodule

`default_nettype wire

// File: rtl/ppu_vram_arbiter.sv
// ============================================================================
// ppu_vram_arbiter : shares nametable VRAM between render fetches and CPU
// Revision 1.0
// ============================================================================
`default_nettype none

module ppu_vram_arbiter
  import ppu_vram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ppu_clk_en,
  input  mirror_t             mirroring,
  ppu_vram_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  cpu_arb_state_t   state;
  logic             we_q;
  logic [13:0]      addr_q;
  logic [7:0]       wd_q;
  logic [CNT_W-1:0] starve;
  logic             rd_oor_q;
  logic             rend_oor_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       rd_data_q;
  logic             rend_valid_q;
  logic             rend_stall_q;

  logic             starved;
  logic             cpu_grant;
  logic             rend_grant;
  logic [13:0]      grant_addr;
  logic [10:0]      map_addr;
  logic             in_range;

  // Render has priority unless the pending CPU access has waited out the limit.
  assign starved    = (starve == STARVE_MAX);
  assign cpu_grant  = ppu_clk_en && (state == C_PEND) && (!bus.rend_req || starved);
  assign rend_grant = ppu_clk_en && bus.rend_req && !cpu_grant;
  assign grant_addr = cpu_grant ? addr_q : bus.rend_addr;

  vram_mirror_map u_map (
    .addr      (grant_addr),
    .mirroring (mirroring),
    .vram_addr (map_addr),
    .in_range  (in_range)
  );

  assign bus.vram_addr     = map_addr;
  assign bus.vram_re       = in_range && (rend_grant || (cpu_grant && !we_q));
  assign bus.vram_we       = in_range && cpu_grant && we_q;
  assign bus.vram_wr_data  = wd_q;

  assign bus.rend_rd_valid = rend_valid_q;
  assign bus.rend_rd_data  = rend_oor_q ? 8'h00 : bus.vram_rd_data;
  assign bus.rend_stall    = rend_stall_q;
  assign bus.cpu_busy      = busy_q;
  assign bus.cpu_done      = done_q;
  assign bus.cpu_rd_data   = rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rend_valid_q <= 1'b0;
      rend_stall_q <= 1'b0;
      rend_oor_q   <= 1'b0;
    end else if (ppu_clk_en) begin
      rend_valid_q <= rend_grant;
      rend_stall_q <= bus.rend_req && !rend_grant;
      if (rend_grant) begin
        rend_oor_q <= !in_range;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= C_IDLE;
      we_q      <= 1'b0;
      addr_q    <= 14'h0000;
      wd_q      <= 8'h00;
      starve    <= '0;
      rd_oor_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      case (state)
        C_IDLE: begin
          if (bus.cpu_req) begin
            we_q   <= bus.cpu_we;
            addr_q <= bus.cpu_addr;
            wd_q   <= bus.cpu_wr_data;
            starve <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= C_PEND;
          end
        end
        C_PEND: begin
          if (cpu_grant) begin
            starve   <= '0;
            rd_oor_q <= !in_range;
            if (we_q) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= C_IDLE;
            end else begin
              state  <= C_RDWAIT;
            end
          end else if (ppu_clk_en && bus.rend_req && !starved) begin
            starve <= starve + 1'b1;
          end
        end
        C_RDWAIT: begin
          if (ppu_clk_en) begin
            rd_data_q <= rd_oor_q ? 8'h00 : bus.vram_rd_data;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state     <= C_IDLE;
          end
        end
        default: state <= C_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ppu_vram_arbiter.sv
// ============================================================================
// tb_ppu_vram_arbiter : directed self-checking bench for ppu_vram_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ppu_vram_arbiter;
  import ppu_vram_arbiter_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    ppu_clk_en = 1'b0;
  mirror_t mirroring = VER_MIRROR;

  ppu_vram_arbiter_if bus ();

  ppu_vram_arbiter #(.STARVE_LIMIT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ppu_clk_en (ppu_clk_en),
    .mirroring  (mirroring),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Sync-read nametable RAM model, preloaded with mem[i] = i*7+3.
  logic [7:0] mem [0:2047];
  logic       load = 1'b1;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'((i * 7 + 3) & 255);
    end else begin
      if (bus.vram_we) mem[bus.vram_addr] <= bus.vram_wr_data;
      if (bus.vram_re) bus.vram_rd_data <= mem[bus.vram_addr];
    end
  end

  int both_cnt = 0;
  int offtick_cnt = 0;
  always @(posedge clk) begin
    if (bus.vram_re && bus.vram_we) both_cnt++;
    if ((bus.vram_re || bus.vram_we) && !ppu_clk_en) offtick_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic        cap_re, cap_we;
  logic [10:0] cap_addr;
  logic [7:0]  cap_wd;

  // One ppu tick; strobes are captured just after inputs settle.
  task automatic tick(input logic rr, input logic [13:0] ra);
    @(negedge clk);
    ppu_clk_en    = 1'b1;
    bus.rend_req  = rr;
    bus.rend_addr = ra;
    #1;
    cap_re   = bus.vram_re;
    cap_we   = bus.vram_we;
    cap_addr = bus.vram_addr;
    cap_wd   = bus.vram_wr_data;
    @(negedge clk);
    ppu_clk_en   = 1'b0;
    bus.rend_req = 1'b0;
  endtask

  // CPU pulse on an off-tick cycle.
  task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] d);
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = we;
    bus.cpu_addr    = a;
    bus.cpu_wr_data = d;
    @(negedge clk);
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int forced_tick;
  int rgrants;

  initial begin
    bus.rend_req = 1'b0; bus.rend_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wr_data = '0;
    bus.vram_rd_data = 8'h00;
    repeat (3) @(negedge clk);
    load = 1'b0;
    check_eq("rst_busy",  bus.cpu_busy, 0);
    check_eq("rst_done",  bus.cpu_done, 0);
    check_eq("rst_rdata", bus.cpu_rd_data, 8'h00);
    check_eq("rst_valid", bus.rend_rd_valid, 0);
    check_eq("rst_stall", bus.rend_stall, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: vertical mirroring CPU write
    mirroring = VER_MIRROR;
    cpu_access(1'b1, 14'h2C05, 8'hAB);
    check_eq("t1_busy_pend", bus.cpu_busy, 1);
    tick(1'b0, 14'h0);
    check_eq("t1_we",   {cap_we, cap_re}, 2'b10);
    check_eq("t1_addr", cap_addr, 11'h405);
    check_eq("t1_wd",   cap_wd, 8'hAB);
    check_eq("t1_done", {bus.cpu_done, bus.cpu_busy}, 2'b10);

    // 2: horizontal mirroring CPU read
    mirroring = HOR_MIRROR;
    cpu_access(1'b0, 14'h2C05, 8'h00);
    check_eq("t2_done_clr", bus.cpu_done, 0);
    tick(1'b0, 14'h0);
    check_eq("t2_re",   {cap_we, cap_re}, 2'b01);
    check_eq("t2_addr", cap_addr, 11'h405);
    check_eq("t2_wait", {bus.cpu_done, bus.cpu_busy}, 2'b01);
    tick(1'b0, 14'h0);
    check_eq("t2_rdata", bus.cpu_rd_data, 8'hAB);
    check_eq("t2_done",  {bus.cpu_done, bus.cpu_busy}, 2'b10);

    // 3: starvation guard under continuous rendering
    cpu_access(1'b0, 14'h2000, 8'h00);
    forced_tick = 0;
    rgrants = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1'b1, 14'h2001);
      if (cap_re && cap_addr == 11'h000 && forced_tick == 0) forced_tick = k;
      else if (cap_re && cap_addr == 11'h001) rgrants++;
      if (k == 16) check_eq("t3_stall16", bus.rend_stall, 0);
      if (k == 17) begin
        check_eq("t3_stall17", bus.rend_stall, 1);
        check_eq("t3_valid17", bus.rend_rd_valid, 0);
      end
      if (k == 18) begin
        check_eq("t3_stall18", bus.rend_stall, 0);
        check_eq("t3_valid18", bus.rend_rd_valid, 1);
        check_eq("t3_rdata18", bus.rend_rd_data, 8'h0A);
        check_eq("t3_cpurd",   bus.cpu_rd_data, 8'h03);
        check_eq("t3_done",    {bus.cpu_done, bus.cpu_busy}, 2'b10);
      end
    end
    check_eq("t3_forced_tick", forced_tick, 17);
    check_eq("t3_rgrants", rgrants, 39);

    // 4: render and CPU reads interleaved
    mirroring = VER_MIRROR;
    cpu_access(1'b0, 14'h2C05, 8'h00);
    tick(1'b1, 14'h23C0);
    check_eq("t4_r1_addr", {cap_re, cap_addr}, {1'b1, 11'h3C0});
    check_eq("t4_r1_valid", bus.rend_rd_valid, 1);
    check_eq("t4_r1_data", bus.rend_rd_data, 8'h43);
    tick(1'b0, 14'h0);
    check_eq("t4_c_addr", {cap_re, cap_addr}, {1'b1, 11'h405});
    check_eq("t4_c_valid", bus.rend_rd_valid, 0);
    tick(1'b1, 14'h23C0);
    check_eq("t4_r2_addr", {cap_re, cap_addr}, {1'b1, 11'h3C0});
    check_eq("t4_cpurd", bus.cpu_rd_data, 8'hAB);
    check_eq("t4_r2_valid", bus.rend_rd_valid, 1);
    check_eq("t4_r2_data", bus.rend_rd_data, 8'h43);

    // 5: out-of-range accesses and upper range boundary
    cpu_access(1'b1, 14'h3F00, 8'h77);
    tick(1'b0, 14'h0);
    check_eq("t5_w_strobe", {cap_we, cap_re}, 2'b00);
    check_eq("t5_w_done", bus.cpu_done, 1);
    cpu_access(1'b0, 14'h1000, 8'h00);
    tick(1'b0, 14'h0);
    check_eq("t5_r_strobe", {cap_we, cap_re}, 2'b00);
    tick(1'b0, 14'h0);
    check_eq("t5_r_data", bus.cpu_rd_data, 8'h00);
    check_eq("t5_r_done", bus.cpu_done, 1);
    tick(1'b1, 14'h0010);
    check_eq("t5_rend_strobe", cap_re, 0);
    check_eq("t5_rend_valid", bus.rend_rd_valid, 1);
    check_eq("t5_rend_data", bus.rend_rd_data, 8'h00);
    cpu_access(1'b1, 14'h3EFF, 8'h5C);
    tick(1'b0, 14'h0);
    check_eq("t5_edge_we", {cap_we, cap_addr}, {1'b1, 11'h6FF});

    // 6: request while busy ignored, reset during read wait
    cpu_access(1'b0, 14'h2C05, 8'h00);
    cpu_access(1'b1, 14'h2000, 8'hEE);
    tick(1'b0, 14'h0);
    check_eq("t6_first_wins", {cap_we, cap_re, cap_addr}, {2'b01, 11'h405});
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", bus.cpu_busy, 0);
    check_eq("t6_rst_done", bus.cpu_done, 0);
    check_eq("t6_rst_rdata", bus.cpu_rd_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tick(1'b0, 14'h0);
    check_eq("t6_no_done", bus.cpu_done, 0);
    cpu_access(1'b1, 14'h2001, 8'h99);
    tick(1'b0, 14'h0);
    check_eq("t6_post_we", {cap_we, cap_addr, cap_wd}, {1'b1, 11'h001, 8'h99});
    check_eq("t6_post_done", bus.cpu_done, 1);
    check_eq("t6_mem0", mem[0], 8'h03);
    check_eq("t6_mem1", mem[1], 8'h99);

    check_eq("both_strobes", both_cnt, 0);
    check_eq("offtick_strobes", offtick_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
